// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined floating-point adder/subtractor.
// The default field widths describe IEEE single precision. The pipeline top
// is parametric in EXP_W/MAN_W/TAG_W and takes these values as its defaults.
// The constants, field helpers and stage records below describe the default
// format.
package fp_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_TAG_W = 4;

    // Packed word: {sign, exponent, mantissa}.
    localparam int FP_W       = 1 + FP_EXP_W + FP_MAN_W;
    localparam int FP_SIGN_B  = FP_W - 1;
    localparam int FP_EXP_HI  = FP_W - 2;
    localparam int FP_EXP_LO  = FP_MAN_W;
    localparam int FP_MAN_HI  = FP_MAN_W - 1;

    // Internal mantissa datapath: {carry, hidden, man, guard, round, sticky}.
    localparam int FP_EXT_W = FP_MAN_W + 5;

    localparam logic [FP_W-1:0] FP_ZERO = '0;
    localparam logic [FP_W-1:0] FP_NAN  = '1;

    function automatic logic fp_sign(input logic [FP_W-1:0] x);
        return x[FP_SIGN_B];
    endfunction

    function automatic logic [FP_EXP_W-1:0] fp_exp(input logic [FP_W-1:0] x);
        return x[FP_EXP_HI:FP_EXP_LO];
    endfunction

    function automatic logic [FP_MAN_W-1:0] fp_man(input logic [FP_W-1:0] x);
        return x[FP_MAN_HI:0];
    endfunction

    // Stage records in the default format.
    // Align -> add/sub.
    typedef struct packed {
        logic                vld;
        logic                sign;
        logic                eff_sub;
        logic                force_nan;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_EXT_W-1:0] man_a;
        logic [FP_EXT_W-1:0] man_b;
        logic [FP_TAG_W-1:0] tag;
    } fp_align_rec_t;

    // Add/sub -> normalise. The grs bits are the three LSBs of man.
    typedef struct packed {
        logic                vld;
        logic                sign;
        logic                force_nan;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_EXT_W-1:0] man;
        logic [FP_TAG_W-1:0] tag;
    } fp_sum_rec_t;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter.
// Ports:
//   din_i  W-bit input vector
//   cnt_o  number of leading zeros counted from the MSB; W when din_i is all zeros
module fp_lzc #(
    parameter int W = 27
) (
    input  logic [W-1:0]              din_i,
    output logic [$clog2(W+1)-1:0]    cnt_o
);

    localparam int CW = $clog2(W + 1);

    // Scanning upward means the highest set bit is written last.
    always_comb begin
        cnt_o = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (din_i[i]) begin
                cnt_o = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined floating-point adder/subtractor.
// Rounding is round-to-nearest-even. Denormals are flushed to zero.
// An input with an all-ones exponent forces the all-ones NaN result.
// Stages: S1 swaps and aligns the operands, S2 adds or subtracts the
// mantissas, and S3 normalises, rounds and packs into the output register.
// An operation accepted at one clock edge is presented on out_* after the
// third edge. All stages advance together when en = !out_valid || out_ready.
// Optional build macro FP_ADDSUB_DBG_EN adds a simulation-only transfer log.
// It also adds a check that the output holds steady while stalled.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready = pipeline enable)
//   in_a, in_b            operands {sign, exponent, mantissa}
//   in_sub                1: a-b, 0: a+b
//   in_tag                user tag carried with the operation
//   out_valid / out_ready result handshake
//   out_z, out_tag        result and its tag
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W,
    parameter int TAG_W = FP_TAG_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic                   in_sub,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_z,
    output logic [TAG_W-1:0]       out_tag
);

    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int XW  = MAN_W + 5;            // {carry, hidden, man, g, r, s}
    localparam int LZW = $clog2(XW);           // count width for XW-1 bit input
    localparam int EW  = EXP_W + LZW + 1;      // signed working exponent

    localparam logic signed [EW-1:0] E_ONE  = EW'(1);
    localparam logic signed [EW-1:0] E_ZERO = EW'(0);
    localparam logic signed [EW-1:0] E_MAX  = EW'((2 ** EXP_W) - 1);

    typedef struct packed {
        logic             sign;
        logic             eff_sub;
        logic             force_nan;
        logic [EXP_W-1:0] exp;
        logic [XW-1:0]    man_a;
        logic [XW-1:0]    man_b;
        logic [TAG_W-1:0] tag;
    } align_rec_t;

    typedef struct packed {
        logic             sign;
        logic             force_nan;
        logic [EXP_W-1:0] exp;
        logic [XW-1:0]    man;
        logic [TAG_W-1:0] tag;
    } sum_rec_t;

    // Right shift that ORs every bit shifted out into the sticky LSB.
    // A shift past the datapath width leaves only the sticky bit.
    function automatic logic [XW-1:0] shift_sticky(input logic [XW-1:0] x,
                                                   input logic [EXP_W-1:0] d);
        logic [XW-1:0] lost_mask;
        lost_mask = ~({XW{1'b1}} << d);
        return (x >> d) | {{(XW-1){1'b0}}, |(x & lost_mask)};
    endfunction

    function automatic logic rne_up(input logic lsb, input logic g,
                                    input logic r, input logic s);
        return g & (r | s | lsb);
    endfunction

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // ---------------- S1: classify, swap, align ----------------
    align_rec_t       s1_d, s1_q;
    logic             s1_vld_q, s2_vld_q, out_valid_q;
    logic             a_zero, b_zero, b_sign_eff, a_ge;
    logic [XW-1:0]    a_ext, b_ext, small_ext;
    logic [EXP_W-1:0] a_exp, b_exp;

    always_comb begin
        a_exp      = in_a[W-2:MAN_W];
        b_exp      = in_b[W-2:MAN_W];
        a_zero     = (a_exp == '0);
        b_zero     = (b_exp == '0);
        b_sign_eff = in_b[W-1] ^ in_sub;
        // Zero-exponent operands lose both hidden bit and mantissa.
        a_ext = {1'b0, !a_zero, in_a[MAN_W-1:0] & {MAN_W{!a_zero}}, 3'b000};
        b_ext = {1'b0, !b_zero, in_b[MAN_W-1:0] & {MAN_W{!b_zero}}, 3'b000};
        a_ge  = {a_exp, a_ext} >= {b_exp, b_ext};

        s1_d.sign      = a_ge ? in_a[W-1] : b_sign_eff;
        s1_d.eff_sub   = in_a[W-1] ^ b_sign_eff;
        s1_d.force_nan = (a_exp == '1) || (b_exp == '1);
        s1_d.exp       = a_ge ? a_exp : b_exp;
        s1_d.man_a     = a_ge ? a_ext : b_ext;
        small_ext      = a_ge ? b_ext : a_ext;
        s1_d.man_b     = shift_sticky(small_ext, a_ge ? (a_exp - b_exp) : (b_exp - a_exp));
        s1_d.tag       = in_tag;
    end

    // ---------------- S2: mantissa add/sub ----------------
    sum_rec_t s2_d, s2_q;

    always_comb begin
        s2_d.sign      = s1_q.sign;
        s2_d.force_nan = s1_q.force_nan;
        s2_d.exp       = s1_q.exp;
        s2_d.tag       = s1_q.tag;
        // Swap guarantees man_a >= man_b, so subtraction never goes negative.
        s2_d.man       = s1_q.eff_sub ? (s1_q.man_a - s1_q.man_b)
                                      : (s1_q.man_a + s1_q.man_b);
    end

    // ---------------- S3: normalise, round, pack ----------------
    logic [LZW-1:0]          lz;
    logic [XW-2:0]           norm;
    logic signed [EW-1:0]    e;
    logic [MAN_W+1:0]        rnd;
    logic [MAN_W-1:0]        man_out;
    logic [W-1:0]            z_d;

    fp_lzc #(.W(XW - 1)) u_lzc (
        .din_i (s2_q.man[XW-2:0]),
        .cnt_o (lz)
    );

    always_comb begin
        e = EW'(s2_q.exp);
        if (s2_q.man[XW-1]) begin
            // Carry out: drop one bit into sticky.
            norm = {s2_q.man[XW-1:2], s2_q.man[1] | s2_q.man[0]};
            e    = e + E_ONE;
        end else begin
            norm = s2_q.man[XW-2:0] << lz;
            e    = e - EW'(lz);
        end

        rnd = {1'b0, norm[XW-2:3]} + {{(MAN_W+1){1'b0}},
              rne_up(norm[3], norm[2], norm[1], norm[0])};
        if (rnd[MAN_W+1]) begin
            e       = e + E_ONE;
            man_out = '0;
        end else begin
            man_out = rnd[MAN_W-1:0];
        end

        if (s2_q.force_nan) begin
            z_d = '1;
        end else if (s2_q.man == '0) begin
            z_d = '0;
        end else if (e >= E_MAX) begin
            z_d = '1;
        end else if (e <= E_ZERO) begin
            z_d = '0;
        end else begin
            z_d = {s2_q.sign, e[EXP_W-1:0], man_out};
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q    <= 1'b0;
            s2_vld_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_z       <= '0;
            out_tag     <= '0;
        end else if (en) begin
            s1_vld_q    <= in_valid;
            s2_vld_q    <= s1_vld_q;
            out_valid_q <= s2_vld_q;
            if (s2_vld_q) begin
                out_z   <= z_d;
                out_tag <= s2_q.tag;
            end
        end
    end

    // Stage data is qualified by the valid bits and needs no reset.
    always_ff @(posedge clk) begin
        if (en) begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign out_valid = out_valid_q;

`ifdef FP_ADDSUB_DBG_EN
    logic [2*W:0]     dbg1_q, dbg2_q, dbg3_q;
    logic             dbg_stall_q;
    logic [W-1:0]     dbg_z_q;
    logic [TAG_W-1:0] dbg_tag_q;

    always_ff @(posedge clk) begin
        if (en) begin
            dbg1_q <= {in_sub, in_a, in_b};
            dbg2_q <= dbg1_q;
            dbg3_q <= dbg2_q;
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                $display("fp_addsub_pipe: z=%h tag=%h a=%h b=%h sub=%b", out_z, out_tag,
                         dbg3_q[2*W-1:W], dbg3_q[W-1:0], dbg3_q[2*W]);
            end
            if (dbg_stall_q && (!out_valid || out_z != dbg_z_q || out_tag != dbg_tag_q)) begin
                $error("fp_addsub_pipe: output changed while stalled");
            end
        end
        dbg_stall_q <= rst_n && out_valid && !out_ready;
        dbg_z_q     <= out_z;
        dbg_tag_q   <= out_tag;
    end
`endif

endmodule

// File: tb/tb_fp_addsub_pipe.sv
module tb_fp_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        in_sub = 1'b0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_z;
    logic [3:0]  out_tag;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fp_addsub_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_tag   (out_tag)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", name, got, expv);
        end
    endtask

    // One isolated operation: accepted at the first edge, visible after the third.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [3:0] tag, input logic [31:0] expz);
        @(negedge clk);
        in_a = a; in_b = b; in_sub = sub; in_tag = tag; in_valid = 1'b1; out_ready = 1'b1;
        #1 chk({name, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({name, "_lat1"}, out_valid, 0);
        @(negedge clk);
        chk({name, "_lat2"}, out_valid, 0);
        @(negedge clk);
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_z"}, out_z, expz);
        chk({name, "_tag"}, out_tag, tag);
    endtask

    logic [31:0] st_a [6];
    logic [31:0] st_z [6];
    int          sent, rcv;
    logic        saw_block, prev_stall;
    logic [31:0] hold_z;
    logic [3:0]  hold_tag;

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_z", out_z, 0);
        chk("rst_out_tag", out_tag, 0);
        rst_n = 1'b1;
        #1 chk("rst_in_ready", in_ready, 1);

        // Basic arithmetic
        run_op("one_plus_one",   32'h3F800000, 32'h3F800000, 1'b0, 4'd5, 32'h40000000);
        run_op("one_minus_one",  32'h3F800000, 32'h3F800000, 1'b1, 4'd1, 32'h00000000);
        run_op("three_minus_one",32'h40400000, 32'h3F800000, 1'b1, 4'd2, 32'h40000000);
        run_op("one_minus_0p75", 32'h3F800000, 32'h3F400000, 1'b1, 4'd3, 32'h3E800000);
        run_op("neg1_plus_1",    32'hBF800000, 32'h3F800000, 1'b0, 4'd4, 32'h00000000);
        // RNE tie rounds to even, above-half rounds up
        run_op("rne_tie",        32'h3F800000, 32'h33800000, 1'b0, 4'd6, 32'h3F800000);
        run_op("rne_up",         32'h3F800000, 32'h33C00000, 1'b0, 4'd7, 32'h3F800001);
        // Overflow and special inputs
        run_op("overflow",       32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 4'd8, 32'hFFFFFFFF);
        run_op("nan_a",          32'h7F800000, 32'h3F800000, 1'b0, 4'd9, 32'hFFFFFFFF);
        run_op("nan_b",          32'h3F800000, 32'hFF800001, 1'b1, 4'd10, 32'hFFFFFFFF);
        // Zero operands
        run_op("zero_plus_neg2", 32'h00000000, 32'hC0000000, 1'b0, 4'd11, 32'hC0000000);
        run_op("zero_minus_2",   32'h00000000, 32'h40000000, 1'b1, 4'd12, 32'hC0000000);
        run_op("x_minus_zero",   32'h40400000, 32'h00000000, 1'b1, 4'd13, 32'h40400000);
        run_op("both_neg_zero",  32'h80000000, 32'h80000000, 1'b0, 4'd14, 32'h00000000);
        run_op("underflow",      32'h00800000, 32'h00C00000, 1'b1, 4'd15, 32'h00000000);

        // Streaming with a 5-cycle backpressure window
        st_a = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
        st_z = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000};
        sent = 0; rcv = 0; saw_block = 1'b0; prev_stall = 1'b0;
        hold_z = '0; hold_tag = '0;
        for (int cyc = 0; cyc < 60 && rcv < 6; cyc++) begin
            @(negedge clk);
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_z", out_z, hold_z);
                chk("stall_tag", out_tag, hold_tag);
            end
            out_ready = !(cyc >= 3 && cyc < 8);
            in_valid  = (sent < 6);
            in_a      = (sent < 6) ? st_a[sent] : 32'h0;
            in_b      = 32'h3F800000;
            in_sub    = 1'b0;
            in_tag    = 4'(sent);
            #1;
            if (!in_ready) saw_block = 1'b1;
            if (out_valid && out_ready) begin
                chk("stream_z", out_z, st_z[rcv]);
                chk("stream_tag", out_tag, 4'(rcv));
                rcv++;
            end
            if (in_valid && in_ready) sent++;
            prev_stall = out_valid && !out_ready;
            hold_z     = out_z;
            hold_tag   = out_tag;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", rcv, 6);
        chk("stream_in_ready_dropped", saw_block, 1);
        @(negedge clk);
        chk("stream_no_dup1", out_valid, 0);
        @(negedge clk);
        chk("stream_no_dup2", out_valid, 0);

        // Reset with three operations in flight
        @(negedge clk);
        in_a = 32'h3F800000; in_b = 32'h3F800000; in_sub = 1'b0; in_tag = 4'hA; in_valid = 1'b1;
        @(negedge clk);
        in_tag = 4'hB;
        @(negedge clk);
        in_tag = 4'hC;
        @(negedge clk);
        in_valid = 1'b0;
        chk("inflight_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_z", out_z, 0);
        chk("midrst_out_tag", out_tag, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_stale", out_valid, 0);
        end
        run_op("post_rst_op", 32'h3FC00000, 32'h3F800000, 1'b0, 4'd9, 32'h40200000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
